// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module : conv_pkg
// Shared state type, output-dimension helper and counter width default.
// Rev    : 1.0
// ============================================================================
package conv_pkg;

  localparam int c_cw_default = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Returns 0 when the kernel does not fit, so callers can reject the config.
  function automatic int out_dim(input int img, input int ker, input int pad, input int stride);
    int span;
    span = img + 2 * pad - ker;
    if (span < 0 || stride < 1) return 0;
    return span / stride + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wrap_counter.sv
`default_nettype none
// ============================================================================
// Module : wrap_counter
// Modulo-MAX counter; wrap flags the step that returns it to zero.
// Rev    : 1.0
// ============================================================================
module wrap_counter #(
  parameter int MAX = 2,
  parameter int CW  = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          wrap
);

  localparam logic [CW-1:0] c_last = CW'(MAX - 1);

  logic [CW-1:0] r_count;

  assign wrap  = en && (r_count == c_last);
  assign count = r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear || wrap) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_iterator.sv
`default_nettype none
// ============================================================================
// Module : conv_iterator
// Convolution loop sequencer (ker_x, ker_y, ch, out_x, out_y); CONV_ITER_PAD_EN
// enables zero-pad borders. Rev : 1.0
// ============================================================================
module conv_iterator
  import conv_pkg::*;
#(
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8,
  parameter int KER_W    = 3,
  parameter int KER_H    = 3,
  parameter int CHANNELS = 1,
  parameter int STRIDE   = 1,
  parameter int PAD      = 0,
  parameter int CW       = c_cw_default
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 ready,
  output logic        [CW-1:0] out_x,
  output logic        [CW-1:0] out_y,
  output logic        [CW-1:0] ch,
  output logic        [CW-1:0] ker_x,
  output logic        [CW-1:0] ker_y,
  output logic        [CW-1:0] out_idx,
  output logic signed [CW-1:0] in_row,
  output logic signed [CW-1:0] in_col,
  output logic                 pad_zero,
  output logic                 en_sum,
  output logic                 save,
  output logic                 busy,
  output logic                 finish
);

`ifdef CONV_ITER_PAD_EN
  localparam int c_pad = PAD;
`else
  localparam int c_pad = PAD * 0;
`endif
  localparam int c_out_w = out_dim(IMG_W, KER_W, c_pad, STRIDE);
  localparam int c_out_h = out_dim(IMG_H, KER_H, c_pad, STRIDE);

  generate
    if (c_out_w < 1 || c_out_h < 1) begin : g_bad_cfg
      $error("conv_iterator: output dimension below 1");
    end
  endgenerate

  state_t        r_state, w_state_next;
  logic          w_run, w_step;
  logic          w_wrap_kx, w_wrap_ky, w_wrap_ch, w_wrap_ox, w_wrap_oy;
  logic [CW-1:0] w_kx, w_ky, w_ch, w_ox, w_oy;
  int            w_row, w_col, w_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_RUN;
      ST_RUN:  if (w_wrap_oy) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_run  = (r_state == ST_RUN);
  assign w_step = w_run && ready;

  // Counters are cleared outside RUN; each wrap enables the next level out.
  wrap_counter #(.MAX(KER_W),    .CW(CW)) u_ker_x (.clk(clk), .reset_n(reset_n), .en(w_step),    .clear(!w_run), .count(w_kx), .wrap(w_wrap_kx));
  wrap_counter #(.MAX(KER_H),    .CW(CW)) u_ker_y (.clk(clk), .reset_n(reset_n), .en(w_wrap_kx), .clear(!w_run), .count(w_ky), .wrap(w_wrap_ky));
  wrap_counter #(.MAX(CHANNELS), .CW(CW)) u_ch    (.clk(clk), .reset_n(reset_n), .en(w_wrap_ky), .clear(!w_run), .count(w_ch), .wrap(w_wrap_ch));
  wrap_counter #(.MAX(c_out_w),  .CW(CW)) u_out_x (.clk(clk), .reset_n(reset_n), .en(w_wrap_ch), .clear(!w_run), .count(w_ox), .wrap(w_wrap_ox));
  wrap_counter #(.MAX(c_out_h),  .CW(CW)) u_out_y (.clk(clk), .reset_n(reset_n), .en(w_wrap_ox), .clear(!w_run), .count(w_oy), .wrap(w_wrap_oy));

  always_comb begin
    w_row = int'(w_oy) * STRIDE + int'(w_ky) - c_pad;
    w_col = int'(w_ox) * STRIDE + int'(w_kx) - c_pad;
    w_idx = int'(w_oy) * c_out_w + int'(w_ox);
  end

  assign out_x   = w_ox;
  assign out_y   = w_oy;
  assign ch      = w_ch;
  assign ker_x   = w_kx;
  assign ker_y   = w_ky;
  assign out_idx = CW'(w_idx);
  // Gated so that a negative pad offset never shows outside RUN.
  assign in_row  = w_run ? CW'(w_row) : '0;
  assign in_col  = w_run ? CW'(w_col) : '0;

`ifdef CONV_ITER_PAD_EN
  assign pad_zero = w_run && (w_row < 0 || w_row >= IMG_H || w_col < 0 || w_col >= IMG_W);
`else
  assign pad_zero = 1'b0;
`endif

  assign en_sum = w_step;
  assign save   = w_wrap_ch;
  assign busy   = w_run;
  assign finish = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_conv_iterator.sv
`default_nettype none
// ============================================================================
// Module : tb_conv_iterator
// Directed bench: three iterator configurations sharing clock and reset.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_conv_iterator;

`ifdef CONV_ITER_PAD_EN
  localparam int PE = 1;
`else
  localparam int PE = 0;
`endif

  typedef struct {
    int ox, oy, c, kx, ky, idx, row, col;
    bit pz, sv;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [2:0]        start, ready;
  logic [7:0]        out_x[3], out_y[3], ch[3], ker_x[3], ker_y[3], out_idx[3];
  logic signed [7:0] in_row[3], in_col[3];
  logic [2:0]        pad_zero, en_sum, save, busy, finish;

  int n_vec  = 0;
  int n_miss = 0;

  // dut0: 4x4 k3 s1; dut1: 5x5 k3 s2 ch2; dut2: 4x4 k3 PAD=1
  int CHN[3] = '{1, 2, 1};
  int STR[3] = '{1, 2, 1};
  int PD[3]  = '{0, 0, PE};
  int IMW[3] = '{4, 5, 4};
  int OW[3]  = '{2, 2, 2 + 2 * PE};

  conv_iterator #(.IMG_W(4), .IMG_H(4), .KER_W(3), .KER_H(3), .CHANNELS(1), .STRIDE(1), .PAD(0), .CW(8)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .ready(ready[0]),
    .out_x(out_x[0]), .out_y(out_y[0]), .ch(ch[0]), .ker_x(ker_x[0]), .ker_y(ker_y[0]),
    .out_idx(out_idx[0]), .in_row(in_row[0]), .in_col(in_col[0]), .pad_zero(pad_zero[0]),
    .en_sum(en_sum[0]), .save(save[0]), .busy(busy[0]), .finish(finish[0]));

  conv_iterator #(.IMG_W(5), .IMG_H(5), .KER_W(3), .KER_H(3), .CHANNELS(2), .STRIDE(2), .PAD(0), .CW(8)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .ready(ready[1]),
    .out_x(out_x[1]), .out_y(out_y[1]), .ch(ch[1]), .ker_x(ker_x[1]), .ker_y(ker_y[1]),
    .out_idx(out_idx[1]), .in_row(in_row[1]), .in_col(in_col[1]), .pad_zero(pad_zero[1]),
    .en_sum(en_sum[1]), .save(save[1]), .busy(busy[1]), .finish(finish[1]));

  conv_iterator #(.IMG_W(4), .IMG_H(4), .KER_W(3), .KER_H(3), .CHANNELS(1), .STRIDE(1), .PAD(1), .CW(8)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start[2]), .ready(ready[2]),
    .out_x(out_x[2]), .out_y(out_y[2]), .ch(ch[2]), .ker_x(ker_x[2]), .ker_y(ker_y[2]),
    .out_idx(out_idx[2]), .in_row(in_row[2]), .in_col(in_col[2]), .pad_zero(pad_zero[2]),
    .en_sum(en_sum[2]), .save(save[2]), .busy(busy[2]), .finish(finish[2]));

  // Step k decomposed by mixed radix, innermost ker_x.
  function automatic exp_t model(input int d, input int k);
    exp_t e;
    int per_px;
    per_px = 9 * CHN[d];
    e.kx  = k % 3;
    e.ky  = (k / 3) % 3;
    e.c   = (k / 9) % CHN[d];
    e.ox  = (k / per_px) % OW[d];
    e.oy  = k / (per_px * OW[d]);
    e.idx = e.oy * OW[d] + e.ox;
    e.row = e.oy * STR[d] + e.ky - PD[d];
    e.col = e.ox * STR[d] + e.kx - PD[d];
    e.pz  = (e.row < 0) || (e.row >= IMW[d]) || (e.col < 0) || (e.col >= IMW[d]);
    e.sv  = (e.kx == 2) && (e.ky == 2) && (e.c == CHN[d] - 1);
    return e;
  endfunction

  function automatic bit coord_ok(input int d, input exp_t e);
    return (out_x[d] === 8'(e.ox)) && (out_y[d] === 8'(e.oy)) && (ch[d] === 8'(e.c)) &&
           (ker_x[d] === 8'(e.kx)) && (ker_y[d] === 8'(e.ky)) && (out_idx[d] === 8'(e.idx)) &&
           (in_row[d] === 8'(e.row)) && (in_col[d] === 8'(e.col));
  endfunction

  function automatic string obs_s(input int d);
    return $sformatf("x%0d y%0d c%0d kx%0d ky%0d idx%0d row%0d col%0d",
                     out_x[d], out_y[d], ch[d], ker_x[d], ker_y[d], out_idx[d], in_row[d], in_col[d]);
  endfunction

  function automatic string exp_s(input exp_t e);
    return $sformatf("x%0d y%0d c%0d kx%0d ky%0d idx%0d row%0d col%0d",
                     e.ox, e.oy, e.c, e.kx, e.ky, e.idx, e.row, e.col);
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    start   = '0;
    ready   = '1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_vec++;
      if ({out_x[d], out_y[d], ch[d], ker_x[d], ker_y[d], out_idx[d], in_row[d], in_col[d]} !== 64'd0 ||
          {pad_zero[d], en_sum[d], save[d], busy[d], finish[d]} !== 5'd0) begin
        n_miss++;
        $display("FAIL reset_state dut%0d got %s pz%0b en%0b sv%0b busy%0b fin%0b, want all zero",
                 d, obs_s(d), pad_zero[d], en_sum[d], save[d], busy[d], finish[d]);
      end
    end
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_vec++;
      if (busy[d] !== 1'b0 || finish[d] !== 1'b0) begin
        n_miss++;
        $display("FAIL idle_after_reset dut%0d got busy%0b fin%0b, want 0 0", d, busy[d], finish[d]);
      end
    end
  endtask

  task automatic test_basic();
    exp_t e;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    for (int k = 0; k < 36; k++) begin
      e = model(0, k);
      n_vec++;
      if (en_sum[0] !== 1'b1 || busy[0] !== 1'b1 || finish[0] !== 1'b0) begin
        n_miss++;
        $display("FAIL basic_en step %0d got en%0b busy%0b fin%0b, want 1 1 0", k, en_sum[0], busy[0], finish[0]);
      end
      n_vec++;
      if (!coord_ok(0, e)) begin
        n_miss++;
        $display("FAIL basic_coord step %0d got %s want %s", k, obs_s(0), exp_s(e));
      end
      n_vec++;
      if (save[0] !== ((k % 9) == 8)) begin
        n_miss++;
        $display("FAIL basic_save step %0d got %0b want %0b", k, save[0], (k % 9) == 8);
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (finish[0] !== 1'b1 || busy[0] !== 1'b0 || en_sum[0] !== 1'b0) begin
      n_miss++;
      $display("FAIL basic_finish got fin%0b busy%0b en%0b, want 1 0 0", finish[0], busy[0], en_sum[0]);
    end
    @(posedge clk); #1;
    n_vec++;
    if (finish[0] !== 1'b0 || busy[0] !== 1'b0) begin
      n_miss++;
      $display("FAIL basic_idle got fin%0b busy%0b, want 0 0", finish[0], busy[0]);
    end
  endtask

  task automatic test_stride_channels();
    exp_t e;
    int   nsave;
    int   sidx[4];
    int   want_idx[4] = '{0, 1, 2, 3};
    nsave = 0;
    start[1] = 1'b1;
    @(posedge clk); #1;
    start[1] = 1'b0;
    for (int k = 0; k < 72; k++) begin
      e = model(1, k);
      n_vec++;
      if (!coord_ok(1, e) || en_sum[1] !== 1'b1 || pad_zero[1] !== 1'b0) begin
        n_miss++;
        $display("FAIL stride_coord step %0d got %s en%0b pz%0b want %s en1 pz0",
                 k, obs_s(1), en_sum[1], pad_zero[1], exp_s(e));
      end
      n_vec++;
      if (save[1] !== ((k % 18) == 17)) begin
        n_miss++;
        $display("FAIL stride_save step %0d got %0b want %0b", k, save[1], (k % 18) == 17);
      end
      if (save[1] === 1'b1 && nsave < 4) begin
        sidx[nsave] = int'(out_idx[1]);
        nsave++;
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (nsave !== 4 || finish[1] !== 1'b1) begin
      n_miss++;
      $display("FAIL stride_end got saves%0d fin%0b, want 4 1", nsave, finish[1]);
    end
    for (int i = 0; i < nsave; i++) begin
      n_vec++;
      if (sidx[i] !== want_idx[i]) begin
        n_miss++;
        $display("FAIL stride_save_idx save %0d got %0d want %0d", i, sidx[i], want_idx[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_pad();
    exp_t e;
    int   npz;
    int   tot      = 36 + 108 * PE;
    int   want_pz  = 44 * PE;
    int   first_rc = -PE;
    npz = 0;
    start[2] = 1'b1;
    @(posedge clk); #1;
    start[2] = 1'b0;
    n_vec++;
    if (in_row[2] !== 8'(first_rc) || in_col[2] !== 8'(first_rc) || pad_zero[2] !== 1'(PE)) begin
      n_miss++;
      $display("FAIL pad_first got row%0d col%0d pz%0b want row%0d col%0d pz%0d",
               in_row[2], in_col[2], pad_zero[2], first_rc, first_rc, PE);
    end
    for (int k = 0; k < tot; k++) begin
      e = model(2, k);
      n_vec++;
      if (!coord_ok(2, e) || en_sum[2] !== 1'b1 || pad_zero[2] !== e.pz || save[2] !== e.sv) begin
        n_miss++;
        $display("FAIL pad_coord step %0d got %s en%0b pz%0b sv%0b want %s en1 pz%0b sv%0b",
                 k, obs_s(2), en_sum[2], pad_zero[2], save[2], exp_s(e), e.pz, e.sv);
      end
      if (pad_zero[2] === 1'b1) npz++;
      @(posedge clk); #1;
    end
    n_vec++;
    if (npz !== want_pz || finish[2] !== 1'b1) begin
      n_miss++;
      $display("FAIL pad_end got pz_count%0d fin%0b want %0d 1", npz, finish[2], want_pz);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ready_stall();
    exp_t e;
    int   k, nen, cyc;
    bit   done;
    k = 0; nen = 0; cyc = 0; done = 1'b0;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    while (!done && cyc < 600) begin
      ready[0] = 1'($urandom_range(0, 1));
      #1;
      if (finish[0] === 1'b1) begin
        done = 1'b1;
      end else begin
        e = model(0, k);
        n_vec++;
        if (!coord_ok(0, e) || en_sum[0] !== ready[0] || save[0] !== (ready[0] && e.sv)) begin
          n_miss++;
          $display("FAIL stall_step step %0d rdy%0b got %s en%0b sv%0b want %s en%0b sv%0b",
                   k, ready[0], obs_s(0), en_sum[0], save[0], exp_s(e), ready[0], ready[0] && e.sv);
        end
        if (en_sum[0] === 1'b1) nen++;
        if (ready[0]) k++;
        @(posedge clk); #1;
        cyc++;
      end
    end
    ready[0] = 1'b1;
    n_vec++;
    if (!done || k !== 36 || nen !== 36) begin
      n_miss++;
      $display("FAIL stall_total got done%0b steps%0d en_count%0d want 1 36 36", done, k, nen);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    start[1] = 1'b1;
    @(posedge clk); #1;
    start[1] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    e = model(1, 20);
    n_vec++;
    if (!coord_ok(1, e) || busy[1] !== 1'b1) begin
      n_miss++;
      $display("FAIL rstmid_pre got %s busy%0b want %s busy1", obs_s(1), busy[1], exp_s(e));
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({out_x[1], out_y[1], ch[1], ker_x[1], ker_y[1], out_idx[1], in_row[1], in_col[1]} !== 64'd0 ||
        {en_sum[1], save[1], busy[1], finish[1]} !== 4'd0) begin
      n_miss++;
      $display("FAIL rstmid_async got %s en%0b sv%0b busy%0b fin%0b want all zero",
               obs_s(1), en_sum[1], save[1], busy[1], finish[1]);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (busy[1] !== 1'b0 || en_sum[1] !== 1'b0 || finish[1] !== 1'b0) begin
      n_miss++;
      $display("FAIL rstmid_idle got busy%0b en%0b fin%0b want 0 0 0", busy[1], en_sum[1], finish[1]);
    end
    start[1] = 1'b1;
    @(posedge clk); #1;
    start[1] = 1'b0;
    for (int k = 0; k < 72; k++) begin
      e = model(1, k);
      n_vec++;
      if (!coord_ok(1, e) || en_sum[1] !== 1'b1) begin
        n_miss++;
        $display("FAIL rstmid_rerun step %0d got %s en%0b want %s en1", k, obs_s(1), en_sum[1], exp_s(e));
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (finish[1] !== 1'b1) begin
      n_miss++;
      $display("FAIL rstmid_finish got %0b want 1", finish[1]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    start[0] = 1'b1;
    @(posedge clk); #1;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 36; k++) begin
        // second pass: start toggles during RUN and must be ignored
        if (p == 1) start[0] = ((k % 2) == 0);
        e = model(0, k);
        n_vec++;
        if (!coord_ok(0, e) || en_sum[0] !== 1'b1) begin
          n_miss++;
          $display("FAIL b2b_step pass %0d step %0d got %s en%0b want %s en1", p, k, obs_s(0), en_sum[0], exp_s(e));
        end
        @(posedge clk); #1;
      end
      if (p == 1) start[0] = 1'b0;
      n_vec++;
      if (finish[0] !== 1'b1 || busy[0] !== 1'b0) begin
        n_miss++;
        $display("FAIL b2b_done pass %0d got fin%0b busy%0b want 1 0", p, finish[0], busy[0]);
      end
      @(posedge clk); #1;
      n_vec++;
      if (finish[0] !== 1'b0 || busy[0] !== 1'b0 || en_sum[0] !== 1'b0) begin
        n_miss++;
        $display("FAIL b2b_gap pass %0d got fin%0b busy%0b en%0b want 0 0 0", p, finish[0], busy[0], en_sum[0]);
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (busy[0] !== 1'b0) begin
      n_miss++;
      $display("FAIL b2b_stop got busy%0b want 0", busy[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stride_channels();
    test_pad();
    test_ready_stall();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
